// File: rtl/shift_arbiter.sv
// shift_arbiter
// Shares one combinational barrel shifter (SLL/SRL/SRA, one-hot command)
// between two requesters. A round-robin arbiter picks at most one request
// per cycle. The shifted result is captured in a single registered output
// stage. Valid/ready handshakes are used on every side. When the consumer is
// ready, the block sustains one operation per cycle.
//
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   reqN_valid_i / _ready_o  request handshake for requester N (0/1)
//   reqN_data_i              value to shift
//   reqN_shamt_i             shift amount (only the low SHAMT_W bits are used)
//   reqN_cmd_i               3'b001 SLL, 3'b010 SRL, 3'b100 SRA
//   reqN_tag_i               opaque tag echoed with the result
//   res_valid_o / _ready_i   result handshake
//   res_data_o               shifted value
//   res_id_o                 requester that issued the result
//   res_tag_o                echoed tag
//   res_err_o                command was not a legal one-hot encoding
module shift_arbiter #(
  parameter int bitWidth = 32,
  parameter int TAG_W    = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                req0_valid_i,
  output logic                req0_ready_o,
  input  logic [bitWidth-1:0] req0_data_i,
  input  logic [bitWidth-1:0] req0_shamt_i,
  input  logic [2:0]          req0_cmd_i,
  input  logic [TAG_W-1:0]    req0_tag_i,
  input  logic                req1_valid_i,
  output logic                req1_ready_o,
  input  logic [bitWidth-1:0] req1_data_i,
  input  logic [bitWidth-1:0] req1_shamt_i,
  input  logic [2:0]          req1_cmd_i,
  input  logic [TAG_W-1:0]    req1_tag_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [bitWidth-1:0] res_data_o,
  output logic                res_id_o,
  output logic [TAG_W-1:0]    res_tag_o,
  output logic                res_err_o
);

  localparam int SHAMT_W = $clog2(bitWidth);

  logic                resValid_q, resValid_d;
  logic [bitWidth-1:0] resData_q,  resData_d;
  logic                resId_q,    resId_d;
  logic [TAG_W-1:0]    resTag_q,   resTag_d;
  logic                resErr_q,   resErr_d;
  logic                lastGrant_q, lastGrant_d;

  logic                acceptEn;
  logic                gnt0, gnt1, transfer;
  logic [bitWidth-1:0] selData;
  logic [bitWidth-1:0] selShamt;
  logic [2:0]          selCmd;
  logic [TAG_W-1:0]    selTag;
  logic [SHAMT_W-1:0]  sh;
  logic [bitWidth-1:0] shResult;
  logic                shErr;

  // The upper shift-amount bits are ignored by design.
  logic unusedShamtBits;
  assign unusedShamtBits = ^{req0_shamt_i[bitWidth-1:SHAMT_W],
                             req1_shamt_i[bitWidth-1:SHAMT_W]};

  // The output register can take a new result when it is empty or is being
  // drained this cycle.
  assign acceptEn = !resValid_q || res_ready_i;

  // Round-robin grant. Under contention, the requester that did not win last
  // time is granted. No grant is issued while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset_i && acceptEn) begin
      if (req0_valid_i && req1_valid_i) begin
        if (lastGrant_q) gnt0 = 1'b1;
        else             gnt1 = 1'b1;
      end else if (req0_valid_i) begin
        gnt0 = 1'b1;
      end else if (req1_valid_i) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign transfer     = gnt0 || gnt1;
  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;

  assign selData  = gnt1 ? req1_data_i  : req0_data_i;
  assign selShamt = gnt1 ? req1_shamt_i : req0_shamt_i;
  assign selCmd   = gnt1 ? req1_cmd_i   : req0_cmd_i;
  assign selTag   = gnt1 ? req1_tag_i   : req0_tag_i;
  assign sh       = selShamt[SHAMT_W-1:0];

  // Shared barrel shifter. Illegal commands produce zero with the error flag
  // set, so the operation still returns in order.
  always_comb begin
    shResult = '0;
    shErr    = 1'b0;
    case (selCmd)
      3'b001:  shResult = selData << sh;
      3'b010:  shResult = selData >> sh;
      3'b100:  shResult = $signed(selData) >>> sh;
      default: shErr    = 1'b1;
    endcase
  end

  // Output stage: load on accept. Otherwise, drop valid when the consumer
  // takes the result. The payload holds its value once it has been consumed.
  always_comb begin
    resValid_d  = resValid_q;
    resData_d   = resData_q;
    resId_d     = resId_q;
    resTag_d    = resTag_q;
    resErr_d    = resErr_q;
    lastGrant_d = lastGrant_q;
    if (transfer) begin
      resValid_d  = 1'b1;
      resData_d   = shResult;
      resId_d     = gnt1;
      resTag_d    = selTag;
      resErr_d    = shErr;
      lastGrant_d = gnt1;
    end else if (res_ready_i) begin
      resValid_d = 1'b0;
    end
  end

  // lastGrant resets to 1 so that requester 0 wins the first contention.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      resValid_q  <= 1'b0;
      resData_q   <= '0;
      resId_q     <= 1'b0;
      resTag_q    <= '0;
      resErr_q    <= 1'b0;
      lastGrant_q <= 1'b1;
    end else begin
      resValid_q  <= resValid_d;
      resData_q   <= resData_d;
      resId_q     <= resId_d;
      resTag_q    <= resTag_d;
      resErr_q    <= resErr_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  assign res_valid_o = resValid_q;
  assign res_data_o  = resData_q;
  assign res_id_o    = resId_q;
  assign res_tag_o   = resTag_q;
  assign res_err_o   = resErr_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter
// Self-checking bench for shift_arbiter (bitWidth 32, TAG_W 4).
// Each test task drives one scenario and checks handshake and output signals
// inline. Expected results are pushed to a scoreboard queue at accept time. A
// monitor pops and compares these results whenever the consumer takes a result.
module tb_shift_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic        id;
    logic [3:0]  tag;
    logic        err;
  } res_t;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req0_valid_i, req0_ready_o;
  logic [31:0] req0_data_i, req0_shamt_i;
  logic [2:0]  req0_cmd_i;
  logic [3:0]  req0_tag_i;
  logic        req1_valid_i, req1_ready_o;
  logic [31:0] req1_data_i, req1_shamt_i;
  logic [2:0]  req1_cmd_i;
  logic [3:0]  req1_tag_i;
  logic        res_valid_o, res_ready_i;
  logic [31:0] res_data_o;
  logic        res_id_o;
  logic [3:0]  res_tag_o;
  logic        res_err_o;

  res_t expQ[$];
  int   nChecks = 0;
  int   nPass   = 0;

  shift_arbiter #(.bitWidth(32), .TAG_W(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_data_i(req0_data_i), .req0_shamt_i(req0_shamt_i),
    .req0_cmd_i(req0_cmd_i), .req0_tag_i(req0_tag_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_data_i(req1_data_i), .req1_shamt_i(req1_shamt_i),
    .req1_cmd_i(req1_cmd_i), .req1_tag_i(req1_tag_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_id_o(res_id_o),
    .res_tag_o(res_tag_o), .res_err_o(res_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference shifter built bit by bit from the operation definitions.
  function automatic res_t mkExp(input logic id, input logic [31:0] d,
                                 input logic [31:0] shamt, input logic [2:0] cmd,
                                 input logic [3:0] tag);
    res_t r;
    int   sh;
    sh     = int'(shamt[4:0]);
    r.id   = id;
    r.tag  = tag;
    r.err  = 1'b0;
    r.data = '0;
    for (int i = 0; i < 32; i++) begin
      case (cmd)
        3'b001:  r.data[i] = (i >= sh) ? d[i-sh] : 1'b0;
        3'b010:  r.data[i] = (i + sh < 32) ? d[i+sh] : 1'b0;
        3'b100:  r.data[i] = (i + sh < 32) ? d[i+sh] : d[31];
        default: r.err = 1'b1;
      endcase
    end
    return r;
  endfunction

  task automatic setReq(input int n, input logic v, input logic [31:0] d,
                        input logic [31:0] s, input logic [2:0] c, input logic [3:0] t);
    if (n == 0) begin
      req0_valid_i = v; req0_data_i = d; req0_shamt_i = s; req0_cmd_i = c; req0_tag_i = t;
    end else begin
      req1_valid_i = v; req1_data_i = d; req1_shamt_i = s; req1_cmd_i = c; req1_tag_i = t;
    end
  endtask

  task automatic idle();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
  endtask

  // Scoreboard monitor. It samples just before the rising edge, while the
  // inputs are already stable.
  always @(negedge clk_i) begin
    res_t e;
    #4;
    if (!reset_i && res_valid_o && res_ready_i) begin
      nChecks++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL result: got data=%h id=%0d tag=%0d err=%0d, required no result",
                 res_data_o, res_id_o, res_tag_o, res_err_o);
      end else begin
        e = expQ.pop_front();
        if ({res_data_o, res_id_o, res_tag_o, res_err_o} !== e)
          $display("[TB] FAIL result: got data=%h id=%0d tag=%0d err=%0d, required data=%h id=%0d tag=%0d err=%0d",
                   res_data_o, res_id_o, res_tag_o, res_err_o, e.data, e.id, e.tag, e.err);
        else nPass++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    reset_i = 1'b1; res_ready_i = 1'b0;
    setReq(0, 1'b1, 32'h1, 32'h1, 3'b001, 4'h1);
    setReq(1, 1'b1, 32'h2, 32'h1, 3'b001, 4'h2);
    repeat (2) @(negedge clk_i);
    #1;
    nChecks++; if (req0_ready_o !== 1'b0) $display("[TB] FAIL reset_rdy0: got %b required 0", req0_ready_o); else nPass++;
    nChecks++; if (req1_ready_o !== 1'b0) $display("[TB] FAIL reset_rdy1: got %b required 0", req1_ready_o); else nPass++;
    nChecks++; if (res_valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b required 0", res_valid_o); else nPass++;
    nChecks++; if (res_data_o !== 32'h0) $display("[TB] FAIL reset_data: got %h required 0", res_data_o); else nPass++;
    nChecks++; if ({res_id_o, res_tag_o, res_err_o} !== 6'b0) $display("[TB] FAIL reset_meta: got %b required 0", {res_id_o, res_tag_o, res_err_o}); else nPass++;
    idle();
    reset_i = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk_i);
    res_ready_i = 1'b1;
    setReq(0, 1'b1, 32'h0000_00F0, 32'd4, 3'b001, 4'd3);
    #1;
    nChecks++; if (req0_ready_o !== 1'b1) $display("[TB] FAIL basic_rdy0: got %b required 1", req0_ready_o); else nPass++;
    nChecks++; if (req1_ready_o !== 1'b0) $display("[TB] FAIL basic_rdy1: got %b required 0", req1_ready_o); else nPass++;
    expQ.push_back('{data: 32'h0000_0F00, id: 1'b0, tag: 4'd3, err: 1'b0});
    @(negedge clk_i);
    idle();
    #1;
    nChecks++; if (res_valid_o !== 1'b1) $display("[TB] FAIL basic_latency: got valid %b required 1", res_valid_o); else nPass++;
    nChecks++; if (res_data_o !== 32'h0000_0F00) $display("[TB] FAIL basic_data: got %h required 00000f00", res_data_o); else nPass++;
    @(negedge clk_i);
    #1;
    nChecks++; if (res_valid_o !== 1'b0) $display("[TB] FAIL basic_drain: got valid %b required 0", res_valid_o); else nPass++;
  endtask

  task automatic test_shifts();
    logic [31:0] tD [6];
    logic [31:0] tS [6];
    logic [2:0]  tC [6];
    logic [31:0] tE [6];
    tD = '{32'h8000_0000, 32'h8000_0000, 32'h1, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'hA5A5_0F0F};
    tS = '{32'd31, 32'd31, 32'd33, 32'd0, 32'd32, 32'd0};
    tC = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b010, 3'b100};
    tE = '{32'hFFFF_FFFF, 32'h1, 32'h2, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'hA5A5_0F0F};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      setReq(0, 1'b1, tD[i], tS[i], tC[i], 4'(i + 4));
      #1;
      nChecks++; if (req0_ready_o !== 1'b1) $display("[TB] FAIL shift_rdy0[%0d]: got %b required 1", i, req0_ready_o); else nPass++;
      expQ.push_back('{data: tE[i], id: 1'b0, tag: 4'(i + 4), err: 1'b0});
    end
    @(negedge clk_i);
    idle();
    @(negedge clk_i);
    #1;
    nChecks++; if (res_valid_o !== 1'b0) $display("[TB] FAIL shift_drain: got valid %b required 0", res_valid_o); else nPass++;
  endtask

  task automatic test_illegal();
    @(negedge clk_i);
    setReq(1, 1'b1, 32'hDEAD_BEEF, 32'd5, 3'b011, 4'd9);
    #1;
    nChecks++; if (req1_ready_o !== 1'b1) $display("[TB] FAIL illegal_rdy1: got %b required 1", req1_ready_o); else nPass++;
    expQ.push_back('{data: 32'h0, id: 1'b1, tag: 4'd9, err: 1'b1});
    @(negedge clk_i);
    setReq(1, 1'b1, 32'h0000_00FF, 32'd4, 3'b010, 4'd2);
    #1;
    nChecks++; if ({res_valid_o, res_err_o, res_id_o} !== 3'b111) $display("[TB] FAIL illegal_flags: got valid/err/id %b required 111", {res_valid_o, res_err_o, res_id_o}); else nPass++;
    nChecks++; if (res_data_o !== 32'h0) $display("[TB] FAIL illegal_data: got %h required 0", res_data_o); else nPass++;
    nChecks++; if (req1_ready_o !== 1'b1) $display("[TB] FAIL illegal_next_rdy1: got %b required 1", req1_ready_o); else nPass++;
    expQ.push_back('{data: 32'h0000_000F, id: 1'b1, tag: 4'd2, err: 1'b0});
    @(negedge clk_i);
    idle();
    #1;
    nChecks++; if (res_err_o !== 1'b0) $display("[TB] FAIL illegal_clear_err: got %b required 0", res_err_o); else nPass++;
    @(negedge clk_i);
  endtask

  task automatic test_round_robin();
    logic [31:0] pD [2];
    logic [31:0] pS [2];
    logic [2:0]  pC [2];
    logic [3:0]  pT [2];
    logic [2:0]  cmds [3];
    logic        ml;
    logic        g;
    cmds = '{3'b001, 3'b010, 3'b100};
    ml   = 1'b1;
    for (int r = 0; r < 2; r++) begin
      pD[r] = $urandom; pS[r] = $urandom; pC[r] = cmds[$urandom_range(0, 2)]; pT[r] = 4'(r);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      setReq(0, 1'b1, pD[0], pS[0], pC[0], pT[0]);
      setReq(1, 1'b1, pD[1], pS[1], pC[1], pT[1]);
      #1;
      g = ~ml;
      nChecks++; if ({req0_ready_o, req1_ready_o} !== {~g, g}) $display("[TB] FAIL rr_grant[%0d]: got rdy0/rdy1 %b required %b", i, {req0_ready_o, req1_ready_o}, {~g, g}); else nPass++;
      if (i > 0) begin
        nChecks++; if (res_valid_o !== 1'b1) $display("[TB] FAIL rr_bubble[%0d]: got valid %b required 1", i, res_valid_o); else nPass++;
      end
      expQ.push_back(mkExp(g, pD[g], pS[g], pC[g], pT[g]));
      ml = g;
      pD[g] = $urandom; pS[g] = $urandom; pC[g] = cmds[$urandom_range(0, 2)]; pT[g] = pT[g] + 4'd2;
    end
    @(negedge clk_i);
    idle();
    #1;
    nChecks++; if (res_valid_o !== 1'b1) $display("[TB] FAIL rr_last: got valid %b required 1", res_valid_o); else nPass++;
    @(negedge clk_i);
    #1;
    nChecks++; if (res_valid_o !== 1'b0) $display("[TB] FAIL rr_drain: got valid %b required 0", res_valid_o); else nPass++;
  endtask

  task automatic test_backpressure();
    @(negedge clk_i);
    res_ready_i = 1'b0;
    setReq(0, 1'b1, 32'h0000_1234, 32'd8, 3'b001, 4'd6);
    #1;
    nChecks++; if (req0_ready_o !== 1'b1) $display("[TB] FAIL bp_first: got %b required 1", req0_ready_o); else nPass++;
    expQ.push_back('{data: 32'h0012_3400, id: 1'b0, tag: 4'd6, err: 1'b0});
    @(negedge clk_i);
    idle();
    setReq(1, 1'b1, 32'hF000_0000, 32'd4, 3'b100, 4'd7);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk_i);
      #1;
      nChecks++; if ({req0_ready_o, req1_ready_o} !== 2'b00) $display("[TB] FAIL bp_ready[%0d]: got %b required 00", k, {req0_ready_o, req1_ready_o}); else nPass++;
      nChecks++; if ({res_valid_o, res_data_o, res_tag_o} !== {1'b1, 32'h0012_3400, 4'd6}) $display("[TB] FAIL bp_hold[%0d]: got valid %b data %h tag %0d required 1 00123400 6", k, res_valid_o, res_data_o, res_tag_o); else nPass++;
    end
    @(negedge clk_i);
    res_ready_i = 1'b1;
    #1;
    nChecks++; if (req1_ready_o !== 1'b1) $display("[TB] FAIL bp_release: got %b required 1", req1_ready_o); else nPass++;
    expQ.push_back('{data: 32'hFF00_0000, id: 1'b1, tag: 4'd7, err: 1'b0});
    @(negedge clk_i);
    idle();
    #1;
    nChecks++; if ({res_valid_o, res_id_o} !== 2'b11) $display("[TB] FAIL bp_next: got valid/id %b required 11", {res_valid_o, res_id_o}); else nPass++;
    @(negedge clk_i);
    #1;
    nChecks++; if (res_valid_o !== 1'b0) $display("[TB] FAIL bp_drain: got valid %b required 0", res_valid_o); else nPass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    res_ready_i = 1'b0;
    setReq(0, 1'b1, 32'h3, 32'd1, 3'b001, 4'd1);
    #1;
    nChecks++; if (req0_ready_o !== 1'b1) $display("[TB] FAIL rmid_fill: got %b required 1", req0_ready_o); else nPass++;
    expQ.push_back('{data: 32'h6, id: 1'b0, tag: 4'd1, err: 1'b0});
    @(negedge clk_i);
    setReq(0, 1'b1, 32'h10, 32'd2, 3'b010, 4'd2);
    setReq(1, 1'b1, 32'h20, 32'd3, 3'b010, 4'd3);
    #1;
    nChecks++; if (res_valid_o !== 1'b1) $display("[TB] FAIL rmid_held: got valid %b required 1", res_valid_o); else nPass++;
    reset_i = 1'b1;
    #1;
    nChecks++; if ({req0_ready_o, req1_ready_o} !== 2'b00) $display("[TB] FAIL rmid_noGrant: got %b required 00", {req0_ready_o, req1_ready_o}); else nPass++;
    @(negedge clk_i);
    #1;
    nChecks++; if ({res_valid_o, res_data_o, res_id_o, res_tag_o, res_err_o} !== 39'b0) $display("[TB] FAIL rmid_cleared: got valid %b data %h required 0", res_valid_o, res_data_o); else nPass++;
    expQ.delete();
    reset_i = 1'b0;
    res_ready_i = 1'b1;
    #1;
    nChecks++; if ({req0_ready_o, req1_ready_o} !== 2'b10) $display("[TB] FAIL rmid_firstWin: got %b required 10", {req0_ready_o, req1_ready_o}); else nPass++;
    expQ.push_back('{data: 32'h4, id: 1'b0, tag: 4'd2, err: 1'b0});
    @(negedge clk_i);
    req0_valid_i = 1'b0;
    #1;
    nChecks++; if (req1_ready_o !== 1'b1) $display("[TB] FAIL rmid_second: got %b required 1", req1_ready_o); else nPass++;
    expQ.push_back('{data: 32'h4, id: 1'b1, tag: 4'd3, err: 1'b0});
    @(negedge clk_i);
    idle();
    @(negedge clk_i);
    #1;
    nChecks++; if (res_valid_o !== 1'b0) $display("[TB] FAIL rmid_drain: got valid %b required 0", res_valid_o); else nPass++;
  endtask

  initial begin
    idle();
    res_ready_i = 1'b0;
    test_reset();
    test_basic();
    test_shifts();
    test_illegal();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    @(negedge clk_i);
    nChecks++; if (expQ.size() != 0) $display("[TB] FAIL scoreboard_empty: got %0d pending required 0", expQ.size()); else nPass++;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
